// File: rtl/fm_radio_pkg.sv
// Shared constants for the FM receiver channel path: sizes, channel-select
// coefficients (Q BITS), the fixed-point dequantiser and the FIR FSM states.
package fm_radio_pkg;

  localparam int DATA_SIZE = 32;
  localparam int TAPS      = 20;
  localparam int DECIM     = 10;
  localparam int BITS      = 10;
  localparam int TAP_W     = $clog2(TAPS);
  localparam int CNT_W     = $clog2(DECIM + 1);

  typedef logic [1:0] state_t;
  localparam state_t S_FILL = 2'd0;
  localparam state_t S_MAC  = 2'd1;
  localparam state_t S_OUT  = 2'd2;

  localparam logic signed [DATA_SIZE-1:0] CHANNEL_COEFFS_REAL [TAPS] = '{
    -32'sd12, -32'sd20, -32'sd8,  32'sd25,  32'sd70,  32'sd118, 32'sd160, 32'sd190, 32'sd205, 32'sd210,
     32'sd205, 32'sd190, 32'sd160, 32'sd118, 32'sd70, 32'sd25, -32'sd8,  -32'sd20, -32'sd12, -32'sd5
  };

  localparam logic signed [DATA_SIZE-1:0] CHANNEL_COEFFS_IMAG [TAPS] = '{
     32'sd3,   32'sd7,   32'sd12,  32'sd15,  32'sd14,  32'sd8,  -32'sd2,  -32'sd15, -32'sd27, -32'sd34,
    -32'sd31, -32'sd24, -32'sd13, -32'sd1,   32'sd9,   32'sd14,  32'sd15,  32'sd11,  32'sd6,  -32'sd4
  };

  // Divide by 2**BITS rounding toward zero: bias negatives before the arithmetic shift.
  function automatic logic signed [DATA_SIZE-1:0] dequant(input logic signed [2*DATA_SIZE-1:0] v);
    logic signed [2*DATA_SIZE-1:0] biased;
    biased = v[2*DATA_SIZE-1] ? (v + {{(2*DATA_SIZE-BITS){1'b0}}, {BITS{1'b1}}}) : v;
    return DATA_SIZE'(biased >>> BITS);
  endfunction

endpackage

// File: rtl/channel_fir_decim_cmplx_mac.sv
// One half of the complex MAC: acc += DEQUANT(a*b - c*d), wrapping at DATA_SIZE.
module cmplx_mac
  import fm_radio_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        clear,
  input  logic                        en,
  input  logic signed [DATA_SIZE-1:0] a,
  input  logic signed [DATA_SIZE-1:0] b,
  input  logic signed [DATA_SIZE-1:0] c,
  input  logic signed [DATA_SIZE-1:0] d,
  output logic signed [DATA_SIZE-1:0] acc
);

  logic signed [2*DATA_SIZE-1:0] prod_ab;
  logic signed [2*DATA_SIZE-1:0] prod_cd;
  logic signed [2*DATA_SIZE-1:0] diff;

  always_comb begin
    prod_ab = (2*DATA_SIZE)'(a) * (2*DATA_SIZE)'(b);
    prod_cd = (2*DATA_SIZE)'(c) * (2*DATA_SIZE)'(d);
    diff    = prod_ab - prod_cd;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (en) begin
      acc <= acc + dequant(diff);
    end
  end

endmodule

// File: rtl/channel_fir_decim_fifo.sv
// First-word-fall-through synchronous FIFO used by the test wrapper.
module fir_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 256
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (wr_en && !full) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/channel_fir_decim_top.sv
// Test wrapper: I/Q input FIFO pair -> channel_fir_decim -> I/Q output FIFO pair.
module channel_fir_decim_top
  import fm_radio_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 in_wr_en,
  input  logic [DATA_SIZE-1:0] i_in_din,
  input  logic [DATA_SIZE-1:0] q_in_din,
  output logic                 in_full,
  input  logic                 out_rd_en,
  output logic [DATA_SIZE-1:0] i_out_dout,
  output logic [DATA_SIZE-1:0] q_out_dout,
  output logic                 out_empty
);

  logic                 i_in_full, q_in_full, i_in_empty, q_in_empty, i_in_rd_en, q_in_rd_en;
  logic                 i_out_full, q_out_full, i_out_empty, q_out_empty, out_wr_en;
  logic [DATA_SIZE-1:0] i_in_dout, q_in_dout, i_out, q_out;

  assign in_full   = i_in_full | q_in_full;
  assign out_empty = i_out_empty | q_out_empty;

  fir_fifo #(.WIDTH(DATA_SIZE), .DEPTH(256)) u_i_in (
    .clock(clock), .reset(reset), .wr_en(in_wr_en), .din(i_in_din), .full(i_in_full),
    .rd_en(i_in_rd_en), .dout(i_in_dout), .empty(i_in_empty));

  fir_fifo #(.WIDTH(DATA_SIZE), .DEPTH(256)) u_q_in (
    .clock(clock), .reset(reset), .wr_en(in_wr_en), .din(q_in_din), .full(q_in_full),
    .rd_en(q_in_rd_en), .dout(q_in_dout), .empty(q_in_empty));

  channel_fir_decim u_fir (
    .clock(clock), .reset(reset),
    .i_in_empty(i_in_empty), .q_in_empty(q_in_empty),
    .i_in_rd_en(i_in_rd_en), .q_in_rd_en(q_in_rd_en),
    .i_in_dout(i_in_dout), .q_in_dout(q_in_dout),
    .i_out_full(i_out_full), .q_out_full(q_out_full),
    .out_wr_en(out_wr_en), .i_out(i_out), .q_out(q_out));

  fir_fifo #(.WIDTH(DATA_SIZE), .DEPTH(256)) u_i_out (
    .clock(clock), .reset(reset), .wr_en(out_wr_en), .din(i_out), .full(i_out_full),
    .rd_en(out_rd_en), .dout(i_out_dout), .empty(i_out_empty));

  fir_fifo #(.WIDTH(DATA_SIZE), .DEPTH(256)) u_q_out (
    .clock(clock), .reset(reset), .wr_en(out_wr_en), .din(q_out), .full(q_out_full),
    .rd_en(out_rd_en), .dout(q_out_dout), .empty(q_out_empty));

endmodule

// File: rtl/channel_fir_decim.sv
// Complex channel-select FIR with decimation: fill DECIM samples, run TAPS MACs,
// then write one complex result to the output FIFO pair.
module channel_fir_decim
  import fm_radio_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        i_in_empty,
  input  logic                        q_in_empty,
  output logic                        i_in_rd_en,
  output logic                        q_in_rd_en,
  input  logic signed [DATA_SIZE-1:0] i_in_dout,
  input  logic signed [DATA_SIZE-1:0] q_in_dout,
  input  logic                        i_out_full,
  input  logic                        q_out_full,
  output logic                        out_wr_en,
  output logic signed [DATA_SIZE-1:0] i_out,
  output logic signed [DATA_SIZE-1:0] q_out
);

  state_t                      state;
  logic [CNT_W-1:0]            fill_cnt;
  logic [TAP_W-1:0]            tap;
  logic [TAP_W-1:0]            coef_idx;
  logic signed [DATA_SIZE-1:0] x_r [TAPS];
  logic signed [DATA_SIZE-1:0] x_i [TAPS];
  logic signed [DATA_SIZE-1:0] h_r;
  logic signed [DATA_SIZE-1:0] h_i;
  logic signed [DATA_SIZE-1:0] tap_xr;
  logic signed [DATA_SIZE-1:0] tap_xi;
  logic signed [DATA_SIZE-1:0] acc_r;
  logic signed [DATA_SIZE-1:0] acc_i;
  logic                        pop;
  logic                        write;
  logic                        mac_en;

  assign pop        = (state == S_FILL) && !i_in_empty && !q_in_empty && !reset;
  assign i_in_rd_en = pop;
  assign q_in_rd_en = pop;
  assign write      = (state == S_OUT) && !i_out_full && !q_out_full;
  assign mac_en     = (state == S_MAC);
  assign tap_xr     = x_r[tap];
  assign tap_xi     = x_i[tap];

  // Prefetch: h_r/h_i always hold the coefficient for the current tap, so outside
  // S_MAC the ROM is parked on tap 0 and the first MAC cycle needs no bubble.
  always_comb begin
    coef_idx = '0;
    if (state == S_MAC && tap != TAP_W'(TAPS - 1)) begin
      coef_idx = tap + TAP_W'(1);
    end else begin
      coef_idx = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_FILL;
      fill_cnt  <= '0;
      tap       <= '0;
      h_r       <= '0;
      h_i       <= '0;
      out_wr_en <= 1'b0;
      i_out     <= '0;
      q_out     <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x_r[k] <= '0;
        x_i[k] <= '0;
      end
    end else begin
      out_wr_en <= 1'b0;
      h_r       <= CHANNEL_COEFFS_REAL[coef_idx];
      h_i       <= CHANNEL_COEFFS_IMAG[coef_idx];
      case (state)
        S_FILL: begin
          if (pop) begin
            for (int k = TAPS - 1; k > 0; k--) begin
              x_r[k] <= x_r[k-1];
              x_i[k] <= x_i[k-1];
            end
            x_r[0] <= i_in_dout;
            x_i[0] <= q_in_dout;
            if (fill_cnt == CNT_W'(DECIM - 1)) begin
              fill_cnt <= '0;
              state    <= S_MAC;
            end else begin
              fill_cnt <= fill_cnt + CNT_W'(1);
            end
          end
        end
        S_MAC: begin
          if (tap == TAP_W'(TAPS - 1)) begin
            tap   <= '0;
            state <= S_OUT;
          end else begin
            tap <= tap + TAP_W'(1);
          end
        end
        S_OUT: begin
          if (write) begin
            out_wr_en <= 1'b1;
            i_out     <= acc_r;
            q_out     <= acc_i;
            state     <= S_FILL;
          end
        end
        default: state <= S_FILL;
      endcase
    end
  end

  cmplx_mac u_mac_real (
    .clock (clock),
    .reset (reset),
    .clear (write),
    .en    (mac_en),
    .a     (h_r),
    .b     (tap_xr),
    .c     (h_i),
    .d     (tap_xi),
    .acc   (acc_r)
  );

  cmplx_mac u_mac_imag (
    .clock (clock),
    .reset (reset),
    .clear (write),
    .en    (mac_en),
    .a     (h_r),
    .b     (tap_xi),
    .c     (h_i),
    .d     (tap_xr),
    .acc   (acc_i)
  );

endmodule
